// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the fetch controller
// Contents: fetch_state_e (IDLE, FETCH, DRAIN, DONE), ADDR_W, DATA_W.
package fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous byte FIFO buffering memory read returns
// Ports:
//   clk, reset            clock, synchronous active-high reset (empties FIFO)
//   push, push_data       write one byte (caller guarantees not full)
//   pop                   drop the head byte (ignored when empty)
//   head_data             head byte, 0 when empty
//   count                 number of stored bytes, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // No bypass: a pushed byte is visible the cycle after the push.
  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - streams image_size bytes from memory at base_addr to a valid/ready sink
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, done                 level start (sampled in IDLE), done held until start drops
//   base_addr, image_size       latched when start is accepted
//   mem_addr, mem_rw, mem_en    read port, one byte per strobe, mem_rw always 0
//   mem_data_in                 read data, valid RD_LATENCY cycles after the strobe
//   pixel_data/valid/ready      output stream from the FIFO head
//   stall_cycles                only with FETCH_STALL_CNT_EN: backpressured cycles in FETCH/DRAIN
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] image_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_valid,
  input  logic              pixel_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          state_q, state_d;
  logic                  done_q, done_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     size_q, size_d;
  logic [ADDR_W-1:0]     issued_q, issued_d;
  logic [ADDR_W-1:0]     delivered_q, delivered_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  mem_en_q, mem_en_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [CW-1:0]         fifo_count;
  logic [7:0]            in_flight, outstanding;
  logic                  push, pop, issue;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0]           stall_q, stall_d;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    size_d      = size_q;
    issued_d    = issued_q;
    addr_d      = addr_q;
    mem_en_d    = 1'b0;
    pop         = pixel_valid && pixel_ready;
    push        = pipe_q[RD_LATENCY-1];
    pipe_d      = (pipe_q << 1) | RD_LATENCY'(mem_en_q);
    delivered_d = delivered_q + 32'(pop);

    // Credit covers the strobe on the port now, the return pipe and the FIFO,
    // so every returned byte is guaranteed a free FIFO slot.
    in_flight = 8'(mem_en_q);
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + 8'(pipe_q[i]);
    outstanding = 8'(fifo_count) + in_flight;
    issue = (state_q == FETCH) && (issued_q < size_q) && (outstanding < 8'(FIFO_DEPTH));

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base_addr;
          size_d      = image_size;
          issued_d    = '0;
          delivered_d = '0;
          state_d     = (image_size == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          mem_en_d = 1'b1;
          addr_d   = base_q + issued_q;
          issued_d = issued_q + 32'd1;
          if (issued_d == size_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (delivered_d == size_q) state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);

`ifdef FETCH_STALL_CNT_EN
    stall_d = stall_q;
    if (state_q == IDLE && start)
      stall_d = '0;
    else if ((state_q == FETCH || state_q == DRAIN) && pixel_valid && !pixel_ready && stall_q != '1)
      stall_d = stall_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      base_q      <= '0;
      size_q      <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      addr_q      <= '0;
      mem_en_q    <= 1'b0;
      pipe_q      <= '0;
`ifdef FETCH_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      base_q      <= base_d;
      size_q      <= size_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      addr_q      <= addr_d;
      mem_en_q    <= mem_en_d;
      pipe_q      <= pipe_d;
`ifdef FETCH_STALL_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_data_in),
    .pop       (pop),
    .head_data (pixel_data),
    .count     (fifo_count)
  );

  assign done        = done_q;
  assign mem_addr    = addr_q;
  assign mem_en      = mem_en_q;
  assign mem_rw      = 1'b0;
  assign pixel_valid = (fifo_count != '0);
`ifdef FETCH_STALL_CNT_EN
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller (RD_LATENCY 1 and 3 instances)
module tb_fetch_controller;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, start, ready;
  logic [31:0] base_addr, image_size;

  logic        done1, rw1, en1, pv1;
  logic [31:0] addr1;
  logic [7:0]  din1, pd1;
  logic        done3, rw3, en3, pv3;
  logic [31:0] addr3;
  logic [7:0]  din3, pd3;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall1, stall3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_controller #(.RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .done(done1),
    .base_addr(base_addr), .image_size(image_size),
    .mem_addr(addr1), .mem_rw(rw1), .mem_en(en1), .mem_data_in(din1),
    .pixel_data(pd1), .pixel_valid(pv1), .pixel_ready(ready)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall1)
`endif
  );

  fetch_controller #(.RD_LATENCY(3), .FIFO_DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .done(done3),
    .base_addr(base_addr), .image_size(image_size),
    .mem_addr(addr3), .mem_rw(rw3), .mem_en(en3), .mem_data_in(din3),
    .pixel_data(pd3), .pixel_valid(pv3), .pixel_ready(ready)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall3)
`endif
  );

  // Memory contents: a fixed function of the byte address (0..63 at base 0).
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24];
  endfunction

  // Memory models: data appears RD_LATENCY cycles after the strobe cycle, garbage otherwise.
  logic [7:0] line1;
  logic [7:0] line3 [3];
  always @(posedge clk) begin
    line1    <= en1 ? mem_byte(addr1) : 8'hEE;
    line3[0] <= en3 ? mem_byte(addr3) : 8'hEE;
    line3[1] <= line3[0];
    line3[2] <= line3[1];
  end
  assign din1 = line1;
  assign din3 = line3[2];

  // Monitors: log issued addresses, accepted pixels and the peak of bytes held in the block.
  logic [31:0] addr_log1[$], addr_log3[$];
  logic [7:0]  pix_log1[$],  pix_log3[$];
  int          max_out1, max_out3;

  always @(negedge clk) begin
    if (!reset) begin
      if (en1) addr_log1.push_back(addr1);
      if (en3) addr_log3.push_back(addr3);
      if (int'(addr_log1.size()) - int'(pix_log1.size()) > max_out1)
        max_out1 = int'(addr_log1.size()) - int'(pix_log1.size());
      if (int'(addr_log3.size()) - int'(pix_log3.size()) > max_out3)
        max_out3 = int'(addr_log3.size()) - int'(pix_log3.size());
      if (pv1 && ready) pix_log1.push_back(pd1);
      if (pv3 && ready) pix_log3.push_back(pd3);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log1.delete(); addr_log3.delete();
    pix_log1.delete();  pix_log3.delete();
    max_out1 = 0; max_out3 = 0;
  endtask

  // Runs until both instances report done, drops start, then compares the logs
  // against the reference: address base+i and byte mem_byte(base+i) for i < size.
  task automatic finish_and_check(input logic [31:0] b, input logic [31:0] s,
                                  input int pct, input string tag);
    int cyc = 0;
    int err1 = 0;
    int err3 = 0;
    while (!(done1 && done3) && cyc < 5000) begin
      @(posedge clk); #1;
      ready = ($urandom_range(99) < pct);
      cyc++;
    end
    check({tag, " timeout"}, 64'(cyc < 5000), 64'(1));
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " done drop"}, {done1, done3}, 2'b00);
    check({tag, " issues"}, {32'(addr_log1.size()), 32'(addr_log3.size())}, {s, s});
    check({tag, " pixels"}, {32'(pix_log1.size()), 32'(pix_log3.size())}, {s, s});
    for (int i = 0; i < int'(s) && i < addr_log1.size() && i < pix_log1.size(); i++)
      if (addr_log1[i] !== b + 32'(i) || pix_log1[i] !== mem_byte(b + 32'(i))) err1++;
    for (int i = 0; i < int'(s) && i < addr_log3.size() && i < pix_log3.size(); i++)
      if (addr_log3[i] !== b + 32'(i) || pix_log3[i] !== mem_byte(b + 32'(i))) err3++;
    check({tag, " seq L1"}, 64'(err1), 64'(0));
    check({tag, " seq L3"}, 64'(err3), 64'(0));
    check({tag, " credit"}, {32'(max_out1 <= DEPTH), 32'(max_out3 <= DEPTH)}, {32'd1, 32'd1});
  endtask

  task automatic run(input logic [31:0] b, input logic [31:0] s, input int pct, input string tag);
    clear_logs();
    base_addr = b; image_size = s; start = 1'b1;
    finish_and_check(b, s, pct, tag);
  endtask

  typedef struct {
    logic        start;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_pv;
    logic [7:0]  exp_pd;
    logic        exp_done;
  } cyc_vec_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] size;
    int          pct;
    logic [31:0] exp_last_addr;
  } run_vec_t;

  cyc_vec_t cyc_tbl[10];
  run_vec_t run_tbl[5];

  initial begin : main
    // Cycle-exact vectors for base 0x100, size 4, ready 1 on the RD_LATENCY=1 instance.
    for (int k = 0; k < 10; k++) begin
      cyc_tbl[k].start    = (k < 8);
      cyc_tbl[k].exp_en   = (k >= 1 && k <= 4);
      cyc_tbl[k].exp_addr = 32'h100 + 32'(k) - 32'd1;
      cyc_tbl[k].exp_pv   = (k >= 3 && k <= 6);
      cyc_tbl[k].exp_pd   = mem_byte(32'h100 + 32'(k) - 32'd3);
      cyc_tbl[k].exp_done = (k == 7 || k == 8);
    end
    run_tbl[0] = '{32'h0000_0100, 32'd4,  100, 32'h0000_0103};
    run_tbl[1] = '{32'h0000_0000, 32'd64, 50,  32'h0000_003F};
    run_tbl[2] = '{32'hFFFF_FFFE, 32'd4,  100, 32'h0000_0001};
    run_tbl[3] = '{32'h0000_0055, 32'd1,  100, 32'h0000_0055};
    run_tbl[4] = '{32'h0000_1000, 32'd17, 30,  32'h0000_1010};

    reset = 1'b1; start = 1'b0; ready = 1'b1; base_addr = '0; image_size = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check("reset L1", {done1, en1, rw1, addr1, pv1, pd1}, '0);
    check("reset L3", {done3, en3, rw3, addr3, pv3, pd3}, '0);
    reset = 1'b0;

    // Directed cycle-by-cycle sequence.
    base_addr = 32'h100; image_size = 32'd4; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("cyc%0d en", k), en1, cyc_tbl[k].exp_en);
      if (cyc_tbl[k].exp_en) check($sformatf("cyc%0d addr", k), addr1, cyc_tbl[k].exp_addr);
      check($sformatf("cyc%0d pv", k), pv1, cyc_tbl[k].exp_pv);
      if (cyc_tbl[k].exp_pv) check($sformatf("cyc%0d pd", k), pd1, cyc_tbl[k].exp_pd);
      check($sformatf("cyc%0d done", k), done1, cyc_tbl[k].exp_done);
      start = cyc_tbl[k].start;
    end
    repeat (4) @(posedge clk);
    #1;

    // Zero-size image: straight to DONE, no reads.
    clear_logs();
    base_addr = 32'h500; image_size = 32'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("size0 done", {done1, done3}, 2'b11);
    check("size0 en", {en1, en3}, 2'b00);
    @(negedge clk);
    check("size0 done hold", {done1, done3}, 2'b11);
    start = 1'b0;
    @(posedge clk); #1;
    check("size0 done drop", {done1, done3}, 2'b00);
    check("size0 no reads", 64'(addr_log1.size() + addr_log3.size()), 64'(0));

    // Backpressure: exactly DEPTH reads go out while the sink stalls.
    clear_logs();
    ready = 1'b0; base_addr = 32'h2000; image_size = 32'd16; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("stall issues", {32'(addr_log1.size()), 32'(addr_log3.size())}, {32'(DEPTH), 32'(DEPTH)});
    check("stall en low", {en1, en3}, 2'b00);
    check("stall valid", {pv1, pv3}, 2'b11);
    finish_and_check(32'h2000, 32'd16, 100, "stall");

    // Table-driven runs.
    for (int r = 0; r < 5; r++) begin
      run(run_tbl[r].base, run_tbl[r].size, run_tbl[r].pct, $sformatf("tbl%0d", r));
      if (addr_log1.size() != 0)
        check($sformatf("tbl%0d last addr", r), addr_log1[$], run_tbl[r].exp_last_addr);
    end

    // Reset mid-FETCH with reads in flight, then a clean new run.
    clear_logs();
    ready = 1'b1; base_addr = 32'h3000; image_size = 32'd16; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midreset L1", {done1, en1, rw1, addr1, pv1, pd1}, '0);
    check("midreset L3", {done3, en3, rw3, addr3, pv3, pd3}, '0);
    reset = 1'b0;
    run(32'h4000, 32'd8, 70, "post reset");

    // Randomized runs.
    for (int r = 0; r < 6; r++)
      run($urandom, 32'($urandom_range(1, 40)), int'($urandom_range(20, 100)), $sformatf("rand%0d", r));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
